// File: rtl/imem_fetch_responder.sv
// Instruction memory that answers fetches one cycle later through a 2-deep in-order response FIFO.
// Define IMEM_RANGE_CHECK_EN to turn misaligned or out-of-range fetches into NOP_WORD with rsp_err=1.
module imem_fetch_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   fifo_data_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   fetch_data_s;

`ifdef IMEM_RANGE_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);
  logic [1:0] fifo_err_r;
  logic       fetch_err_s;
`else
  logic       unused_addr_s;
`endif

  // ready and valid come straight from the registered occupancy, never from rsp_ready
  assign req_ready = (count_r < 2'd2);
  assign rsp_valid = (count_r != 2'd0);
  assign push_s    = req_valid && req_ready;
  assign pop_s     = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_data_r[rd_ptr_r];

  // Fetch word selection: load-forwarding gives write-first behaviour on a same-word collision
  always_comb begin
    idx_s        = req_addr[AW+1:2];
    fetch_data_s = 32'h0000_0000;
`ifdef IMEM_RANGE_CHECK_EN
    fetch_err_s  = 1'b0;
    if ((req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT)) begin
      fetch_err_s  = 1'b1;
      fetch_data_s = NOP_WORD;
    end else if (ld_en && (ld_addr == idx_s)) begin
      fetch_data_s = ld_data;
    end else begin
      fetch_data_s = mem_r[idx_s];
    end
`else
    if (ld_en && (ld_addr == idx_s)) begin
      fetch_data_s = ld_data;
    end else begin
      fetch_data_s = mem_r[idx_s];
    end
`endif
  end

`ifdef IMEM_RANGE_CHECK_EN
  assign rsp_err = fifo_err_r[rd_ptr_r];
`else
  assign rsp_err       = 1'b0;
  assign unused_addr_s = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Program load port; contents survive reset, but writes are blocked while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n) begin
      if (ld_en) begin
        mem_r[ld_addr] <= ld_data;
      end
    end
  end

  // Response FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r        <= 2'd0;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      fifo_data_r[0] <= 32'h0000_0000;
      fifo_data_r[1] <= 32'h0000_0000;
`ifdef IMEM_RANGE_CHECK_EN
      fifo_err_r     <= 2'b00;
`endif
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= fetch_data_s;
`ifdef IMEM_RANGE_CHECK_EN
        fifo_err_r[wr_ptr_r]  <= fetch_err_s;
`endif
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed vector table, hand sequences, and
// randomized traffic against a queue-based reference model. Honours IMEM_RANGE_CHECK_EN.
module tb_imem_fetch_responder;
  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_data;
  logic           rsp_err;
  logic           ld_en;
  logic [AW-1:0]  ld_addr;
  logic [31:0]    ld_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    bit          rv;
    logic [31:0] ra;
    bit          rr;
    bit          le;
    logic [7:0]  la;
    logic [31:0] ld;
    bit          ev;
    logic [31:0] ed;
    bit          ee;
    bit          er;
  } vec_t;

  logic [31:0] mem_m [DEPTH];
  rsp_t        q [$];
  vec_t        tbl [$];

  imem_fetch_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: what a fetch of addr returns, from the address rules and the current load strobe.
  function automatic rsp_t model_fetch(input logic [31:0] addr);
    rsp_t        r;
    int unsigned idx;
`ifdef IMEM_RANGE_CHECK_EN
    if ((addr % 4 != 0) || (addr >= 4 * DEPTH)) begin
      r.data = NOP;
      r.err  = 1'b1;
      return r;
    end
`endif
    idx    = (addr / 4) % DEPTH;
    r.data = (ld_en && (ld_addr == idx)) ? ld_data : mem_m[idx];
    r.err  = 1'b0;
    return r;
  endfunction

  task automatic check_outputs();
    check("req_ready", req_ready, q.size() < 2);
    check("rsp_valid", rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("rsp_data", rsp_data, q[0].data);
      check("rsp_err", rsp_err, q[0].err);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at the falling edge.
  task automatic cycle(input bit rv, input logic [31:0] ra, input bit rr,
                       input bit le, input logic [AW-1:0] la, input logic [31:0] ld);
    bit   acc;
    bit   pop;
    rsp_t r;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    ld_en = le; ld_addr = la; ld_data = ld;
    acc = rv && (q.size() < 2);
    pop = (q.size() != 0) && rr;
    r   = model_fetch(ra);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(r);
    if (le) mem_m[la] = ld;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic vec_t mk(input bit rv, input logic [31:0] ra, input bit rr, input bit le,
                              input logic [7:0] la, input logic [31:0] ld, input bit ev,
                              input logic [31:0] ed, input bit ee, input bit er);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.le = le; v.la = la; v.ld = ld;
    v.ev = ev; v.ed = ed; v.ee = ee; v.er = er;
    return v;
  endfunction

  initial begin
    logic [31:0] ra;
    int unsigned sel;

    reset_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 32'h0);
    reset_n = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 32'h1);

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 8'(i), $urandom());

    // Directed table: program load, streaming fetch, write-first, address rules
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'd0, 32'h0050_0093, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'd1, 32'h0030_0113, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'd2, 32'h4020_81B3, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'd3, 32'h0000_000B, 0, 32'h0, 0, 1));
    tbl.push_back(mk(1, 32'h0, 1, 0, 8'd0, 32'h0, 1, 32'h0050_0093, 0, 1));
    tbl.push_back(mk(1, 32'h4, 1, 0, 8'd0, 32'h0, 1, 32'h0030_0113, 0, 1));
    tbl.push_back(mk(1, 32'h8, 1, 0, 8'd0, 32'h0, 1, 32'h4020_81B3, 0, 1));
    tbl.push_back(mk(1, 32'hC, 1, 0, 8'd0, 32'h0, 1, 32'h0000_000B, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'd0, 32'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(1, 32'h14, 1, 1, 8'd5, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'd0, 32'h0, 0, 32'h0, 0, 1));
`ifdef IMEM_RANGE_CHECK_EN
    tbl.push_back(mk(1, 32'h2, 1, 0, 8'd0, 32'h0, 1, 32'h0000_0013, 1, 1));
    tbl.push_back(mk(1, 32'h400, 1, 0, 8'd0, 32'h0, 1, 32'h0000_0013, 1, 1));
`else
    tbl.push_back(mk(1, 32'h2, 1, 0, 8'd0, 32'h0, 1, 32'h0050_0093, 0, 1));
    tbl.push_back(mk(1, 32'h400, 1, 0, 8'd0, 32'h0, 1, 32'h0050_0093, 0, 1));
`endif
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'd0, 32'h0, 0, 32'h0, 0, 1));

    foreach (tbl[i]) begin
      cycle(tbl[i].rv, tbl[i].ra, tbl[i].rr, tbl[i].le, tbl[i].la, tbl[i].ld);
      check($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].ev);
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].er);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_data", i), rsp_data, tbl[i].ed);
        check($sformatf("tbl%0d_err", i), rsp_err, tbl[i].ee);
      end
    end

    // Backpressure: three requests offered with rsp_ready low, only two accepted
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 8'd0, 32'h0);
    check("bp_full_ready", req_ready, 32'h0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 8'd0, 32'h0);
    check("bp_frozen_data", rsp_data, 32'h0050_0093);
    check("bp_still_full", req_ready, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0);
    check("bp_second_data", rsp_data, 32'h0030_0113);
    check("bp_second_valid", rsp_valid, 32'h1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0);
    check("bp_drained", rsp_valid, 32'h0);

    // Reset with two responses pending; a load attempted during reset must be dropped
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 8'd0, 32'h0);
    #2;
    reset_n = 1'b0; req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 8'd3; ld_data = 32'hFFFF_FFFF;
    #1;
    check("rst_mid_valid", rsp_valid, 32'h0);
    check("rst_mid_data", rsp_data, 32'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; ld_en = 1'b0;
    #1;
    check("rst_rel_ready", req_ready, 32'h1);
    check("rst_rel_valid", rsp_valid, 32'h0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 8'd0, 32'h0);
    check("rst_mem_kept", rsp_data, 32'h0000_000B);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) ra = $urandom();
      else if (sel == 1) ra = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
      else ra = $urandom_range(0, DEPTH - 1) << 2;
      cycle(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1) ? ra[9:2] : 8'($urandom_range(0, DEPTH - 1)),
            $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_fetch_responder.md
IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit instruction words held; power of two.
REQ-002 Parameter NOP_WORD, 32'h0000_0013, instruction word returned on an erroneous fetch.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, fetch request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-007 The block SHALL have port req_addr, input, 32, byte address of the fetch (the PC).
REQ-008 The block SHALL have port rsp_valid, output, 1, response word present.
REQ-009 The block SHALL have port rsp_ready, input, 1, consumer takes the response when high with rsp_valid.
REQ-010 The block SHALL have port rsp_data, output, 32, fetched instruction word.
REQ-011 The block SHALL have port rsp_err, output, 1, fetch was misaligned or out of range.
REQ-012 The block SHALL have port ld_en, input, 1, program-load write strobe.
REQ-013 The block SHALL have port ld_addr, input, log2(DEPTH), word index for the load write.
REQ-014 The block SHALL have port ld_data, input, 32, instruction word to store.

Function
REQ-015 Storage SHALL be DEPTH x 32 words; word index = req_addr[log2(DEPTH)+1:2].
REQ-016 A request handshake at edge N SHALL make its response visible at rsp_valid/rsp_data after edge N, i.e. 1-cycle latency.
REQ-017 Responses SHALL be held in a 2-entry in-order response FIFO; the occupancy count SHALL range from 0 to 2.
REQ-018 req_ready SHALL be high iff count < 2, derived from registered state only, with no combinational path from rsp_ready.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; push only increments count; pop only decrements it.
REQ-020 With rsp_ready held high, the block SHALL sustain one fetch per cycle with no bubbles.
REQ-021 rsp_valid, rsp_data and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-022 When ld_en=1, ld_data SHALL be written to word ld_addr at the clock edge.
REQ-023 If a load write and an accepted fetch target the same word in the same cycle, the response SHALL return the new ld_data (write-first).
REQ-024 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-025 While reset_n=0: count=0, pointers=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1 after deassertion.
REQ-026 Reset mid-operation SHALL discard all pending responses; memory contents SHALL NOT be cleared by reset.
REQ-027 Load writes SHALL be ignored while reset_n=0.

Configuration
REQ-028 Macro IMEM_RANGE_CHECK_EN SHALL control address checking.
REQ-029 When IMEM_RANGE_CHECK_EN is defined, a fetch with req_addr[1:0]!=0 or with req_addr >= 4*DEPTH SHALL respond with rsp_data=NOP_WORD and rsp_err=1, and memory SHALL NOT be read.
REQ-030 When IMEM_RANGE_CHECK_EN is undefined, req_addr[1:0] and the upper bits SHALL be ignored (the index wraps), and rsp_err SHALL be tied to 0.

Verification
REQ-031 Load words 0..3 with 0x00500093, 0x00300113, 0x402081B3, 0x0000000B; fetch 0x0,0x4,0x8,0xC with rsp_ready=1 -> same words on 4 consecutive cycles, each 1 cycle after its request, req_ready constantly 1.
REQ-032 rsp_ready=0 with 3 requests offered -> 2 accepted, req_ready=0 and rsp_data frozen at word 0; raise rsp_ready -> both responses delivered in order.
REQ-033 Same cycle: ld_en=1, ld_addr=5, ld_data=0xDEADBEEF and fetch 0x14 -> rsp_data=0xDEADBEEF.
REQ-034 With the macro defined: fetch 0x2 -> rsp_data=0x00000013, rsp_err=1; fetch 0x400 -> rsp_data=0x00000013, rsp_err=1. Undefined: fetch 0x400 -> word 0, rsp_err=0.
REQ-035 Pull reset_n low with 2 responses pending -> rsp_valid=0 immediately; after release, count=0 and word 3 still reads 0x0000000B.
